seq_stim_driver: RTL and testbench
==================================

# seq_stim_driver

Stimulus sequencer that drives the `i1`/`i2` inputs of the two-input sequence-detector FSM. On `start` it plays the detector's full 11-transition accept pattern and holds each level for a programmable dwell. It reports completion with a single-cycle `done` pulse and supports abort. It sits between the test/control logic and the detector, and is the only driver of `i1`/`i2`.

## Interface
- `DWELL`, 16, cycles each pattern level is held; must be ≥ 1.
- `GAP`, 4, cycles of `i1`=0, `i2`=0 lead-in before step 1; 0 is legal and skips the lead-in.
- `CW`, 8, dwell/gap counter width; must hold max(`DWELL`, `GAP`) − 1.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a run; sampled only in IDLE.
- `abort`  in  1  cancel a run; sampled in every non-IDLE state.
- `i1`  out  1  detector input 1; registered.
- `i2`  out  1  detector input 2; registered.
- `step`  out  4  current pattern step: 1..11 during STEP, otherwise 0.
- `busy`  out  1  high in LEAD and STEP.
- `done`  out  1  one-cycle pulse at normal completion.
- `aborted`  out  1  one-cycle pulse when a run is cancelled.

## Operation
- States:
  - IDLE: outputs 00, `step`=0, `busy`=0.
  - LEAD: outputs 00.
  - STEP: outputs the pattern level for the current step.
  - DONE: outputs 00, `done`=1.
- Pattern table, as (`i1`,`i2`) for steps 1..11:
  10, 11, 01, 00, 10, 11, 01, 00, 01, 11, 01.
  Each step changes exactly one bit relative to the previous level, and 00 precedes step 1.
- Transitions:
  - IDLE → LEAD on `start`. If `GAP`=0, IDLE → STEP with `step`=1 instead.
  - LEAD → STEP (`step`=1) after `GAP` cycles.
  - STEP → STEP with `step`+1 after `DWELL` cycles, while `step` < 11.
  - STEP with `step`=11 → DONE after `DWELL` cycles.
  - DONE → IDLE unconditionally after 1 cycle.
- Counter: loaded with N−1 on entry to LEAD or STEP (N = `GAP` or `DWELL`), decrements every cycle; the state advances when it reaches 0.
- `start` in LEAD, STEP or DONE is ignored; it is not queued.
- Abort:
  - `abort` in LEAD or STEP moves the block to IDLE on the next edge: outputs 00, `step`=0, `busy`=0, `aborted`=1 for one cycle, and no `done`.
  - `abort` in IDLE or DONE is ignored. In IDLE, `start` is accepted even when `abort` is also high.
  - `abort` on the final cycle of step 11 wins: `aborted` is asserted and `done` is not.
- Reset: an asynchronous assert at any time, including mid-run, forces IDLE immediately. Reset values: `i1`=0, `i2`=0, `step`=0, `busy`=0, `done`=0, `aborted`=0, counter=0.

## Timing
- `start` sampled high at edge T0:
  - `busy`=1 from T0+1 through T0+`GAP`+11·`DWELL`.
  - Step k (1..11) is on `i1`/`i2` for cycles T0+`GAP`+(k−1)·`DWELL`+1 … T0+`GAP`+k·`DWELL`.
  - `done`=1 for the single cycle T0+`GAP`+11·`DWELL`+1, with `busy`=0 and outputs 00 in that cycle.
- The earliest next accepted `start` is sampled at edge T0+`GAP`+11·`DWELL`+2 (back in IDLE).
- All outputs are registered, with no combinational path from `start` or `abort` to any output.
- `abort` sampled at edge Ta: `aborted`=1 and outputs 00 from Ta+1 for exactly one cycle.

## Test plan
- `DWELL`=4, `GAP`=2; `start` at cycle 0:
  - `i1`/`i2` follows 00,00, then each of the 11 levels for 4 cycles.
  - `step` counts 1..11.
  - `done` is a pulse at cycle 47, and the detector reaches its final state.
- `GAP`=0, `DWELL`=1: `start` at cycle 0 → step 1 (10) at cycle 1, step 11 (01) at cycle 11, `done` at cycle 12.
- `abort` during step 5 (`DWELL`=4, `GAP`=2, cycle 20) → at cycle 21: outputs 00, `busy`=0, `aborted`=1 for one cycle; `done` is never asserted.
- `start` pulsed at cycles 10 and 47 of a running sequence (`DWELL`=4, `GAP`=2) → both ignored, timing unchanged; `start` at cycle 48 begins a new run.
- `reset` asserted asynchronously mid-clock during step 7 → all outputs are 0 before the next edge; after release, `start` begins a clean run from the lead-in.
- `abort` on the last cycle of step 11, cycle 46 with `DWELL`=4, `GAP`=2 → `aborted`=1 at cycle 47, `done`=0.

Source files
------------

// File: rtl/seq_stim_driver.sv
// seq_stim_driver: plays the 11-step accept pattern of the two-input sequence
// detector on i1/i2. An optional all-zero lead-in comes first, and each level
// is held for DWELL cycles. Completion is reported with a one-cycle done pulse.
// A run can be cancelled with abort, which gives a one-cycle aborted pulse.
// Every output is a flop computed from the next state, so start/abort never
// reach an output combinationally.
module seq_stim_driver #(
   parameter int unsigned DWELL = 16,  // cycles per pattern level, >= 1
   parameter int unsigned GAP   = 4,   // lead-in cycles of 00, 0 skips it
   parameter int unsigned CW    = 8    // counter width, holds max(DWELL,GAP)-1
) (
   input  logic       clk_i,
   input  logic       reset_ni,
   input  logic       start_i,
   input  logic       abort_i,
   output logic       i1_o,
   output logic       i2_o,
   output logic [3:0] step_o,
   output logic       busy_o,
   output logic       done_o,
   output logic       aborted_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LEAD = 2'd1,
      S_STEP = 2'd2,
      S_DONE = 2'd3
   } state_e;

   localparam logic [3:0]    FIRST_STEP = 4'd1;
   localparam logic [3:0]    LAST_STEP  = 4'd11;
   localparam logic [CW-1:0] DWELL_LD   = CW'(DWELL - 1);
   // GAP-1 would wrap when GAP is 0; the lead-in is never entered in that case.
   localparam logic [CW-1:0] GAP_LD     = (GAP > 0) ? CW'(GAP - 1) : '0;
   localparam logic [CW-1:0] CNT_ONE    = CW'(1);

   // (i1,i2) level for each pattern step; anything outside 1..11 drives 00.
   function automatic logic [1:0] pat_level(input logic [3:0] s);
      logic [1:0] lv;
      case (s)
         4'd1:    lv = 2'b10;
         4'd2:    lv = 2'b11;
         4'd3:    lv = 2'b01;
         4'd4:    lv = 2'b00;
         4'd5:    lv = 2'b10;
         4'd6:    lv = 2'b11;
         4'd7:    lv = 2'b01;
         4'd8:    lv = 2'b00;
         4'd9:    lv = 2'b01;
         4'd10:   lv = 2'b11;
         4'd11:   lv = 2'b01;
         default: lv = 2'b00;
      endcase
      return lv;
   endfunction

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    step_q, step_d;
   logic          i1_q, i1_d;
   logic          i2_q, i2_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          aborted_q, aborted_d;
   logic [1:0]    lvl_d;

   // Next-state: sequencing, dwell/gap counter and abort handling.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      step_d    = step_q;
      aborted_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            // abort is ignored here, so start wins even with abort high
            if (start_i) begin
               if (GAP == 0) begin
                  state_d = S_STEP;
                  step_d  = FIRST_STEP;
                  cnt_d   = DWELL_LD;
               end else begin
                  state_d = S_LEAD;
                  cnt_d   = GAP_LD;
               end
            end
         end
         S_LEAD: begin
            if (abort_i) begin
               state_d   = S_IDLE;
               cnt_d     = '0;
               aborted_d = 1'b1;
            end else if (cnt_q == '0) begin
               state_d = S_STEP;
               step_d  = FIRST_STEP;
               cnt_d   = DWELL_LD;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         S_STEP: begin
            // abort is checked before the step-11 expiry, so it beats done
            if (abort_i) begin
               state_d   = S_IDLE;
               step_d    = '0;
               cnt_d     = '0;
               aborted_d = 1'b1;
            end else if (cnt_q == '0) begin
               if (step_q == LAST_STEP) begin
                  state_d = S_DONE;
                  step_d  = '0;
                  cnt_d   = '0;
               end else begin
                  step_d = step_q + 4'd1;
                  cnt_d  = DWELL_LD;
               end
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            step_d  = '0;
            cnt_d   = '0;
         end
      endcase
   end

   // Output next-values come from the next state, so the flops line up with it.
   always_comb begin
      lvl_d  = (state_d == S_STEP) ? pat_level(step_d) : 2'b00;
      i1_d   = lvl_d[1];
      i2_d   = lvl_d[0];
      busy_d = (state_d == S_LEAD) || (state_d == S_STEP);
      done_d = (state_d == S_DONE);
   end

   // State, counter and registered outputs; reset drops everything to idle at once.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         step_q    <= '0;
         i1_q      <= 1'b0;
         i2_q      <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         aborted_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         step_q    <= step_d;
         i1_q      <= i1_d;
         i2_q      <= i2_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         aborted_q <= aborted_d;
      end
   end

   assign i1_o      = i1_q;
   assign i2_o      = i2_q;
   assign step_o    = step_q;
   assign busy_o    = busy_q;
   assign done_o    = done_q;
   assign aborted_o = aborted_q;

endmodule

// File: tb/tb_seq_stim_driver.sv
// Bench for seq_stim_driver. Instance A uses DWELL=4, GAP=2 and instance B
// uses DWELL=1, GAP=0. Expected outputs come from a timeline model.
// The model tracks only the accepted start edge and the abort edge, and it
// derives every output from the arithmetic timing rules.
module tb_seq_stim_driver;

   logic       clk;
   logic       rst_n;
   logic       start_a, abort_a, start_b, abort_b;
   logic       i1_a, i2_a, busy_a, done_a, aborted_a;
   logic       i1_b, i2_b, busy_b, done_b, aborted_b;
   logic [3:0] step_a, step_b;
   logic [8:0] out_a, out_b;

   int nchk = 0;
   int nerr = 0;

   bit st [0:255];   // start_i value per edge for the next play
   int ab_edge;      // edge at which abort_i is high, -1 for none

   // pattern levels {i1,i2} for steps 1..11, index 0 unused
   localparam logic [1:0] PAT [0:11] = '{2'b00, 2'b10, 2'b11, 2'b01, 2'b00, 2'b10,
                                         2'b11, 2'b01, 2'b00, 2'b01, 2'b11, 2'b01};

   seq_stim_driver #(.DWELL(4), .GAP(2), .CW(8)) dut_a (
      .clk_i(clk), .reset_ni(rst_n), .start_i(start_a), .abort_i(abort_a),
      .i1_o(i1_a), .i2_o(i2_a), .step_o(step_a), .busy_o(busy_a),
      .done_o(done_a), .aborted_o(aborted_a));

   seq_stim_driver #(.DWELL(1), .GAP(0), .CW(8)) dut_b (
      .clk_i(clk), .reset_ni(rst_n), .start_i(start_b), .abort_i(abort_b),
      .i1_o(i1_b), .i2_o(i2_b), .step_o(step_b), .busy_o(busy_b),
      .done_o(done_b), .aborted_o(aborted_b));

   assign out_a = {i1_a, i2_a, step_a, busy_a, done_a, aborted_a};
   assign out_b = {i1_b, i2_b, step_b, busy_b, done_b, aborted_b};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected {i1,i2,step,busy,done,aborted} for the cycle rel cycles after the
   // start edge. arel is the abort edge relative to start, or -1 for none.
   function automatic logic [8:0] prof(input int g, input int d, input int rel, input int arel);
      int k;
      if (arel >= 0 && rel > arel) return (rel == arel + 1) ? 9'b0_0000_0001 : 9'b0;
      if (rel >= 1 && rel <= g) return 9'b0_0000_0100;
      if (rel > g && rel <= g + 11 * d) begin
         k = (rel - g - 1) / d + 1;
         return {PAT[k], 4'(k), 3'b100};
      end
      if (rel == g + 11 * d + 1) return 9'b0_0000_0010;
      return 9'b0;
   endfunction

   task automatic clear_stim();
      for (int i = 0; i < 256; i++) st[i] = 1'b0;
      ab_edge = -1;
   endtask

   // Drive st[]/ab_edge into one instance for ncyc edges and check every cycle.
   task automatic play(input int which, input int ncyc, input string nm);
      int g, d, t0, abt;
      bit idle, busy, s, a;
      logic [8:0] ex, ac;
      g = (which == 0) ? 2 : 0;
      d = (which == 0) ? 4 : 1;
      t0 = -1000;
      abt = -1;
      for (int e = 0; e < ncyc; e++) begin
         s = st[e];
         a = (e == ab_edge);
         if (which == 0) begin start_a = s; abort_a = a; end
         else begin start_b = s; abort_b = a; end
         idle = (abt >= 0) ? (e > abt) : (e >= t0 + g + 11 * d + 2);
         busy = (abt < 0) && (e >= t0 + 1) && (e <= t0 + g + 11 * d);
         if (idle && s) begin
            t0 = e;
            abt = -1;
         end else if (busy && a) begin
            abt = e;
         end
         @(posedge clk);
         #1;
         ex = prof(g, d, e + 1 - t0, (abt >= 0) ? abt - t0 : -1);
         ac = (which == 0) ? out_a : out_b;
         nchk++;
         if (ac !== ex) begin
            nerr++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", nm, e + 1, ac, ex);
         end
      end
      start_a = 1'b0; abort_a = 1'b0; start_b = 1'b0; abort_b = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start_a = 1'b0; abort_a = 1'b0; start_b = 1'b0; abort_b = 1'b0;
      #12;
      nchk++;
      if (out_a !== 9'b0) begin nerr++; $display("FAIL reset_a got=%h exp=0", out_a); end
      nchk++;
      if (out_b !== 9'b0) begin nerr++; $display("FAIL reset_b got=%h exp=0", out_b); end
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      nchk++;
      if (out_a !== 9'b0) begin nerr++; $display("FAIL idle_a got=%h exp=0", out_a); end
      nchk++;
      if (out_b !== 9'b0) begin nerr++; $display("FAIL idle_b got=%h exp=0", out_b); end
   endtask

   task automatic test_full_run();
      clear_stim();
      st[0] = 1'b1;
      play(0, 52, "full_run");
   endtask

   task automatic test_gap0();
      clear_stim();
      st[0] = 1'b1;
      play(1, 16, "gap0");
   endtask

   task automatic test_abort_mid();
      clear_stim();
      st[0] = 1'b1;
      ab_edge = 20;
      play(0, 52, "abort_step5");
   endtask

   task automatic test_abort_last();
      clear_stim();
      st[0] = 1'b1;
      ab_edge = 46;
      play(0, 52, "abort_last");
   endtask

   task automatic test_start_ignored();
      clear_stim();
      st[0] = 1'b1; st[10] = 1'b1; st[47] = 1'b1; st[48] = 1'b1;
      play(0, 100, "back_to_back");
   endtask

   task automatic test_abort_with_start_idle();
      // abort high alongside start in IDLE must not block the start
      clear_stim();
      st[2] = 1'b1;
      ab_edge = 2;
      play(1, 16, "start_abort_idle");
   endtask

   task automatic test_reset_midrun();
      clear_stim();
      st[0] = 1'b1;
      play(0, 28, "pre_reset");
      #3 rst_n = 1'b0;
      #1;
      nchk++;
      if (out_a !== 9'b0) begin nerr++; $display("FAIL async_reset got=%h exp=0", out_a); end
      #1 rst_n = 1'b1;
      clear_stim();
      st[0] = 1'b1;
      play(0, 52, "post_reset");
   endtask

   task automatic test_random();
      int s0, lim;
      for (int it = 0; it < 8; it++) begin
         clear_stim();
         s0 = int'($urandom_range(0, 5));
         st[s0] = 1'b1;
         lim = s0 + 47;
         if ($urandom_range(0, 1) == 1) begin
            ab_edge = s0 + int'($urandom_range(1, 47));
            lim = ab_edge;
         end
         for (int j = 0; j < 3; j++) st[s0 + int'($urandom_range(1, lim - s0))] = 1'b1;
         play(0, s0 + 50, "random");
      end
   endtask

   initial begin
      test_reset();
      test_full_run();
      test_gap0();
      test_abort_mid();
      test_abort_last();
      test_start_ignored();
      test_abort_with_start_idle();
      test_reset_midrun();
      test_random();
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

   initial begin
      #200000;
      nerr++;
      $display("FAIL watchdog got=timeout exp=finish");
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $fatal(1, "timeout");
   end

endmodule
